rv32_decode_unit: RTL and testbench
===================================

// Module: rv32_decode_unit
// PURPOSE
//  RV32I decode block for the single-issue core: decodes the fetched instruction into datapath controls,
//  generates the sign-extended immediate and serves read-only performance CSRs. Sits between imem_data and
//  the regfile/ALU/dmem/PC-select muxes. Loads take 2 cycles; every other instruction takes 1.
// PARAMETERS
//  none
// PORTS
//  clk        in   1   clock; all state updates on posedge
//  reset      in   1   synchronous, active-high reset
//  ins        in   32  current instruction (opcode[6:0] funct3[14:12] funct7[31:25] csr[31:20])
//  imm        out  32  sign-extended immediate
//  op_illegal out  1   undecodable instruction
//  alu_op     out  3   0 ADD,1 SLL,2 SLT,3 SLTU,4 XOR,5 SRL,6 OR,7 AND
//  alu_alt    out  1   SUB instead of ADD / SRA instead of SRL
//  alu_imm    out  1   ALU B = imm (else rs2)
//  alu_a0     out  1   ALU A = 0;  alu_apc out 1: ALU A = pc;  alu_b4 out 1: ALU B = 4 (overrides alu_imm)
//  alu_mul    out  1   rd takes multiplier result
//  reg_wen    out  1   write rd this cycle
//  pc_imm     out  3   0 HOLD(+0),1 +4,2 BNZ(!zero?imm:4),3 BZ(zero?imm:4),4 JAL(+imm),5 JALR(abs rs1+imm)
//  dmem_read / dmem_write / dmem_reg  out 1 each: load request, store, rd takes load data
//  csr_reg    out  1   rd takes csr_rdata;  csr_rdata out 32: CSR read data for ins[31:20]
//  stage0     out  1   first cycle of current instruction
// BEHAVIOUR
//  - imm by opcode: I(LOAD,OP-IMM,JALR,SYSTEM) {20{i31},i[31:20]}; S {i[31:25],i[11:7]}; B {i[31],i[7],
//    i[30:25],i[11:8],0}; U {i[31:12],12'b0}; J {i[31],i[19:12],i[20],i[30:21],0}; all sign-extended; else 0.
//  - Default outputs 0, pc_imm=1. Decode (combinational):
//    LUI 0110111: a0,imm,ADD,wen.  AUIPC 0010111: apc,imm,ADD,wen.
//    JAL 1101111: apc,b4,ADD,wen,pc_imm=4.  JALR 1100111(f3=0): apc,b4,wen,pc_imm=5.
//    BRANCH 1100011: BEQ/BNE ADD+alt, pc 3/2; BLT/BGE SLT, pc 2/3; BLTU/BGEU SLTU, pc 2/3; f3 2,3 illegal.
//    LOAD 0000011: alu_imm,ADD,dmem_read; stage0=1 cycle: pc_imm=0,wen=0; stage0=0 cycle: dmem_reg,wen,pc_imm=1.
//    STORE 0100011: alu_imm,ADD,dmem_write, 1 cycle.  FENCE 0001111: nop.
//    OP-IMM 0010011: alu_imm,op=f3,wen; alt=ins[30] only when f3=5.
//    OP 0110011: op=f3,wen; alt=ins[30] for f3 0/5 with f7 0x20; f7 not 0x00/0x20 illegal (see CONFIG).
//    SYSTEM 1110011: f3!=0 -> csr_reg,wen (CSR writes ignored); f3=0 (ecall/ebreak) illegal.
//  - Illegal: op_illegal=1, wen/dmem_read/dmem_write=0, pc_imm=1.
//  - Stage FSM: s0 (stage0=1) -> s1 only on LOAD; s1 -> s0 always. reset -> s0.
//  - CSRs: 64-bit cycle (+1 every non-reset cycle), instret (+1 per retired instr, i.e. each non-reset
//    cycle except LOAD in s0; illegal counts). 0xC00/0xC01 cycle lo, 0xC80/0xC81 cycle hi, 0xC02 instret lo,
//    0xC82 instret hi; other addrs read 0. Read value = counter before this cycle's increment. Wrap mod 2^64.
//  - Reset (sync): while reset=1 outputs forced to nop (wen/dmem_*/csr_reg/op_illegal=0, pc_imm=1), FSM->s0,
//    counters->0. Reset during LOAD s1 aborts load (no rd write).
// CONFIGURATION
//  MUL_EN: defined -> OP with f7=0000001 legal: alu_mul=1, wen=1, alu_op=f3 (MUL..REMU).
//          undefined -> such encodings are illegal, alu_mul tied 0.
// TESTING
//  addi x1,x0,-1 (0xFFF00093) -> imm=FFFFFFFF, alu_imm=1, op=0, wen=1, pc_imm=1, stage0=1.
//  lw x2,4(x1) (0x0040A103) -> cyc1: dmem_read=1,pc_imm=0,wen=0; cyc2: stage0=0,dmem_reg=1,wen=1,pc_imm=1.
//  bge x1,x2,-8 (0xFE20DCE3) -> imm=FFFFFFF8, op=SLT, pc_imm=3; bne (0xFE209CE3) -> ADD,alt=1,pc_imm=2.
//  reset 1 cycle, then 10 nops, csrrs x3,cycle,x0 (0xC00021F3) -> csr_reg=1, csr_rdata=10; instret reads 10.
//  0x02000033: MUL_EN -> alu_mul=1,wen=1; no MUL_EN -> op_illegal=1,wen=0; 0xFFFFFFFF -> op_illegal=1.
//  reset asserted in LOAD s1 -> next cycle stage0=1, wen=0, counters 0.

Source files
------------

// File: rtl/rv32_decode_unit_if.sv
// ----------------------------------------------------------------------------
// rv32_decode_unit_if
//   Bundle between the fetch stage (which drives the instruction word) and the
//   decode unit (which returns datapath controls, immediate and CSR data).
//
//   master : fetch/datapath side -- drives ins, observes every decode output
//   slave  : decode unit side    -- observes ins, drives every decode output
//
//   Signals
//     ins        current 32-bit instruction word
//     imm        sign-extended immediate
//     op_illegal undecodable instruction
//     alu_op     0 ADD,1 SLL,2 SLT,3 SLTU,4 XOR,5 SRL,6 OR,7 AND
//     alu_alt    SUB instead of ADD / SRA instead of SRL
//     alu_imm    ALU B operand = imm (else rs2)
//     alu_a0     ALU A operand = 0
//     alu_apc    ALU A operand = pc
//     alu_b4     ALU B operand = 4 (overrides alu_imm)
//     alu_mul    rd takes the multiplier result
//     reg_wen    write rd this cycle
//     pc_imm     0 HOLD,1 +4,2 BNZ,3 BZ,4 JAL,5 JALR
//     dmem_read  load request
//     dmem_write store request
//     dmem_reg   rd takes load data
//     csr_reg    rd takes csr_rdata
//     csr_rdata  CSR read data for ins[31:20]
//     stage0     first cycle of the current instruction
// ----------------------------------------------------------------------------
interface rv32_decode_unit_if;
    logic [31:0] ins;
    logic [31:0] imm;
    logic        op_illegal;
    logic [2:0]  alu_op;
    logic        alu_alt;
    logic        alu_imm;
    logic        alu_a0;
    logic        alu_apc;
    logic        alu_b4;
    logic        alu_mul;
    logic        reg_wen;
    logic [2:0]  pc_imm;
    logic        dmem_read;
    logic        dmem_write;
    logic        dmem_reg;
    logic        csr_reg;
    logic [31:0] csr_rdata;
    logic        stage0;

    modport master (
        output ins,
        input  imm, op_illegal, alu_op, alu_alt, alu_imm, alu_a0, alu_apc,
               alu_b4, alu_mul, reg_wen, pc_imm, dmem_read, dmem_write,
               dmem_reg, csr_reg, csr_rdata, stage0
    );

    modport slave (
        input  ins,
        output imm, op_illegal, alu_op, alu_alt, alu_imm, alu_a0, alu_apc,
               alu_b4, alu_mul, reg_wen, pc_imm, dmem_read, dmem_write,
               dmem_reg, csr_reg, csr_rdata, stage0
    );
endinterface

// File: rtl/rv32_decode_unit.sv
// ----------------------------------------------------------------------------
// rv32_decode_unit
//   RV32I decode block for the single-issue core. Turns the fetched
//   instruction into datapath controls, builds the sign-extended immediate and
//   serves the read-only cycle/instret performance counters. Loads take two
//   cycles (address phase, then write-back); everything else takes one.
//
//   Ports
//     clk    clock, all state updates on posedge
//     reset  synchronous, active-high reset; forces nop controls, FSM to the
//            first stage and both counters to zero
//     dec    rv32_decode_unit_if.slave -- ins in, all decode outputs out
//
//   Build option
//     MUL_EN  when defined, OP encodings with funct7 = 0000001 (MUL..REMU)
//             are legal and steer rd to the multiplier; otherwise they decode
//             as illegal and alu_mul stays 0.
// ----------------------------------------------------------------------------
module rv32_decode_unit (
    input  logic               clk,
    input  logic               reset,
    rv32_decode_unit_if.slave  dec
);

`ifdef MUL_EN
    localparam bit MUL_ENABLED = 1'b1;
`else
    localparam bit MUL_ENABLED = 1'b0;
`endif

    // Major opcodes
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    // ALU operations used directly by the decoder
    localparam logic [2:0] ALU_ADD  = 3'd0;
    localparam logic [2:0] ALU_SLT  = 3'd2;
    localparam logic [2:0] ALU_SLTU = 3'd3;

    // Next-PC selects
    localparam logic [2:0] PC_HOLD = 3'd0;
    localparam logic [2:0] PC_NEXT = 3'd1;
    localparam logic [2:0] PC_BNZ  = 3'd2;
    localparam logic [2:0] PC_BZ   = 3'd3;
    localparam logic [2:0] PC_JAL  = 3'd4;
    localparam logic [2:0] PC_JALR = 3'd5;

    // funct7 values on OP
    localparam logic [6:0] F7_BASE = 7'h00;
    localparam logic [6:0] F7_ALT  = 7'h20;
    localparam logic [6:0] F7_MUL  = 7'h01;

    typedef enum logic {
        STAGE_S0,   // first (often only) cycle of an instruction
        STAGE_S1    // load write-back cycle
    } stage_e;

    typedef struct packed {
        logic       op_illegal;
        logic [2:0] alu_op;
        logic       alu_alt;
        logic       alu_imm;
        logic       alu_a0;
        logic       alu_apc;
        logic       alu_b4;
        logic       alu_mul;
        logic       reg_wen;
        logic [2:0] pc_imm;
        logic       dmem_read;
        logic       dmem_write;
        logic       dmem_reg;
        logic       csr_reg;
    } ctrl_t;

    // Field extraction
    logic [31:0] ins;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [11:0] csr_addr;

    assign ins      = dec.ins;
    assign opcode   = ins[6:0];
    assign funct3   = ins[14:12];
    assign funct7   = ins[31:25];
    assign csr_addr = ins[31:20];

    stage_e      state;
    stage_e      state_next;
    ctrl_t       ctrl;
    logic        illegal;
    logic [31:0] imm;
    logic [31:0] csr_rdata;
    logic [63:0] cycle_cnt;
    logic [63:0] instret_cnt;
    logic        retire;

    // ------------------------------------------------------------------
    // State: stage FSM and performance counters
    // ------------------------------------------------------------------
    // A load's first cycle only issues the address; the instruction retires
    // in its write-back cycle, so it is counted exactly once.
    assign retire = !((opcode == OPC_LOAD) && (state == STAGE_S0));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples values from before the edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= STAGE_S0;
            cycle_cnt   <= '0;
            instret_cnt <= '0;
        end else begin
            state     <= state_next;
            cycle_cnt <= cycle_cnt + 64'd1;
            if (retire) begin
                instret_cnt <= instret_cnt + 64'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Decode and next-stage logic
    // ------------------------------------------------------------------
    // NOTE: every variable gets a default at the top of the block so that no
    // path through the case statements can leave it unassigned (no latches).
    always_comb begin
        state_next  = STAGE_S0;
        illegal     = 1'b0;
        ctrl        = '0;
        ctrl.pc_imm = PC_NEXT;

        unique case (opcode)
            OPC_LUI: begin
                ctrl.alu_a0  = 1'b1;
                ctrl.alu_imm = 1'b1;
                ctrl.reg_wen = 1'b1;
            end

            OPC_AUIPC: begin
                ctrl.alu_apc = 1'b1;
                ctrl.alu_imm = 1'b1;
                ctrl.reg_wen = 1'b1;
            end

            // rd = pc + 4 through the ALU; the target is computed by the PC mux
            OPC_JAL: begin
                ctrl.alu_apc = 1'b1;
                ctrl.alu_b4  = 1'b1;
                ctrl.reg_wen = 1'b1;
                ctrl.pc_imm  = PC_JAL;
            end

            OPC_JALR: begin
                if (funct3 == 3'd0) begin
                    ctrl.alu_apc = 1'b1;
                    ctrl.alu_b4  = 1'b1;
                    ctrl.reg_wen = 1'b1;
                    ctrl.pc_imm  = PC_JALR;
                end else begin
                    illegal = 1'b1;
                end
            end

            // Equality compares subtract and test for zero; ordering compares
            // use SLT/SLTU and test the 0/1 result. The "negated" forms
            // (BNE, BGE, BGEU) simply swap the zero/non-zero PC select.
            OPC_BRANCH: begin
                unique case (funct3)
                    3'd0: begin ctrl.alu_op = ALU_ADD;  ctrl.alu_alt = 1'b1; ctrl.pc_imm = PC_BZ;  end
                    3'd1: begin ctrl.alu_op = ALU_ADD;  ctrl.alu_alt = 1'b1; ctrl.pc_imm = PC_BNZ; end
                    3'd4: begin ctrl.alu_op = ALU_SLT;  ctrl.pc_imm = PC_BNZ; end
                    3'd5: begin ctrl.alu_op = ALU_SLT;  ctrl.pc_imm = PC_BZ;  end
                    3'd6: begin ctrl.alu_op = ALU_SLTU; ctrl.pc_imm = PC_BNZ; end
                    3'd7: begin ctrl.alu_op = ALU_SLTU; ctrl.pc_imm = PC_BZ;  end
                    default: illegal = 1'b1;
                endcase
            end

            // The PC is held during the address cycle so the same load word
            // is presented again for the write-back cycle.
            OPC_LOAD: begin
                ctrl.alu_imm   = 1'b1;
                ctrl.dmem_read = 1'b1;
                if (state == STAGE_S0) begin
                    ctrl.pc_imm = PC_HOLD;
                    state_next  = STAGE_S1;
                end else begin
                    ctrl.dmem_reg = 1'b1;
                    ctrl.reg_wen  = 1'b1;
                end
            end

            OPC_STORE: begin
                ctrl.alu_imm    = 1'b1;
                ctrl.dmem_write = 1'b1;
            end

            // Single in-order core with no caches: fences have nothing to order.
            OPC_FENCE: begin
            end

            // ins[30] selects SRAI only on the shift-right encoding; on other
            // funct3 values it is just an immediate bit.
            OPC_OPIMM: begin
                ctrl.alu_imm = 1'b1;
                ctrl.alu_op  = funct3;
                ctrl.alu_alt = (funct3 == 3'd5) && ins[30];
                ctrl.reg_wen = 1'b1;
            end

            OPC_OP: begin
                unique case (funct7)
                    F7_BASE: begin
                        ctrl.alu_op  = funct3;
                        ctrl.reg_wen = 1'b1;
                    end
                    F7_ALT: begin
                        ctrl.alu_op  = funct3;
                        ctrl.alu_alt = (funct3 == 3'd0) || (funct3 == 3'd5);
                        ctrl.reg_wen = 1'b1;
                    end
                    F7_MUL: begin
                        if (MUL_ENABLED) begin
                            ctrl.alu_op  = funct3;
                            ctrl.alu_mul = 1'b1;
                            ctrl.reg_wen = 1'b1;
                        end else begin
                            illegal = 1'b1;
                        end
                    end
                    default: illegal = 1'b1;
                endcase
            end

            // Counters are read-only: any CSR op just returns the current
            // value to rd and the write half is dropped.
            OPC_SYSTEM: begin
                if (funct3 != 3'd0) begin
                    ctrl.csr_reg = 1'b1;
                    ctrl.reg_wen = 1'b1;
                end else begin
                    illegal = 1'b1;
                end
            end

            default: illegal = 1'b1;
        endcase

        // Illegal encodings become a flagged nop that still advances the PC.
        if (illegal) begin
            ctrl            = '0;
            ctrl.pc_imm     = PC_NEXT;
            ctrl.op_illegal = 1'b1;
        end

        // Reset overrides everything, including aborting a pending load write.
        if (reset) begin
            ctrl        = '0;
            ctrl.pc_imm = PC_NEXT;
            state_next  = STAGE_S0;
        end
    end

    // ------------------------------------------------------------------
    // Immediate generation
    // ------------------------------------------------------------------
    always_comb begin
        imm = '0;
        unique case (opcode)
            OPC_LOAD, OPC_OPIMM, OPC_JALR, OPC_SYSTEM:
                imm = {{20{ins[31]}}, ins[31:20]};
            OPC_STORE:
                imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
            OPC_BRANCH:
                imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            OPC_LUI, OPC_AUIPC:
                imm = {ins[31:12], 12'b0};
            OPC_JAL:
                imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
            default:
                imm = '0;
        endcase
        if (reset) begin
            imm = '0;
        end
    end

    // ------------------------------------------------------------------
    // CSR read port: values are the counters before this cycle's increment
    // ------------------------------------------------------------------
    always_comb begin
        csr_rdata = '0;
        unique case (csr_addr)
            12'hC00, 12'hC01: csr_rdata = cycle_cnt[31:0];    // cycle, time
            12'hC80, 12'hC81: csr_rdata = cycle_cnt[63:32];   // cycleh, timeh
            12'hC02:          csr_rdata = instret_cnt[31:0];
            12'hC82:          csr_rdata = instret_cnt[63:32];
            default:          csr_rdata = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // Output drive
    // ------------------------------------------------------------------
    assign dec.imm        = imm;
    assign dec.op_illegal = ctrl.op_illegal;
    assign dec.alu_op     = ctrl.alu_op;
    assign dec.alu_alt    = ctrl.alu_alt;
    assign dec.alu_imm    = ctrl.alu_imm;
    assign dec.alu_a0     = ctrl.alu_a0;
    assign dec.alu_apc    = ctrl.alu_apc;
    assign dec.alu_b4     = ctrl.alu_b4;
    assign dec.alu_mul    = ctrl.alu_mul;
    assign dec.reg_wen    = ctrl.reg_wen;
    assign dec.pc_imm     = ctrl.pc_imm;
    assign dec.dmem_read  = ctrl.dmem_read;
    assign dec.dmem_write = ctrl.dmem_write;
    assign dec.dmem_reg   = ctrl.dmem_reg;
    assign dec.csr_reg    = ctrl.csr_reg;
    assign dec.csr_rdata  = csr_rdata;
    assign dec.stage0     = (state == STAGE_S0);

endmodule

// File: tb/tb_rv32_decode_unit.sv
// ----------------------------------------------------------------------------
// tb_rv32_decode_unit
//   Scoreboard bench for rv32_decode_unit. The driver applies one instruction
//   per cycle, asks a behavioural model what the decoder must show for it and
//   queues that; the monitor pops one entry per cycle and compares.
// ----------------------------------------------------------------------------
module tb_rv32_decode_unit;

`ifdef MUL_EN
    localparam bit MODEL_MUL = 1'b1;
`else
    localparam bit MODEL_MUL = 1'b0;
`endif

    localparam logic [1:0] K_FULL    = 2'd0;
    localparam logic [1:0] K_ILLEGAL = 2'd1;
    localparam logic [1:0] K_RESET   = 2'd2;

    typedef struct packed {
        logic [1:0]  kind;
        logic [31:0] ins;
        logic [31:0] imm;
        logic        ill;
        logic [2:0]  op;
        logic        alt, aimm, a0, apc, b4, mul, wen;
        logic [2:0]  pc;
        logic        dr, dw, dreg, csr;
        logic [31:0] csrd;
        logic        st0;
    } exp_t;

    logic clk;
    logic reset;
    rv32_decode_unit_if dec_if ();

    rv32_decode_unit dut (
        .clk   (clk),
        .reset (reset),
        .dec   (dec_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   tests_run = 0;
    int   tests_failed = 0;
    exp_t sb[$];

    // Model state: "in the second half of a load" plus the two counters
    bit          m_s1;
    logic [63:0] m_cyc;
    logic [63:0] m_inst;

    task automatic check(input string nm, input logic [31:0] ins, input logic [31:0] act,
                         input logic [31:0] req);
        tests_run++;
        if (act !== req) begin
            tests_failed++;
            $display("FAIL %s ins=%h at %0t: got %h, want %h", nm, ins, $time, act, req);
        end
    endtask

    // Immediate built arithmetically from weighted instruction bits
    function automatic logic [31:0] imm_model(input logic [31:0] i);
        int v;
        v = 0;
        case (i[6:0])
            7'b0000011, 7'b0010011, 7'b1100111, 7'b1110011: v = $signed(i) >>> 20;
            7'b0100011: v = (($signed(i) >>> 25) * 32) + int'(i[11:7]);
            7'b1100011: v = (i[31] ? -4096 : 0) + int'(i[7]) * 2048
                            + int'(i[30:25]) * 32 + int'(i[11:8]) * 2;
            7'b0110111, 7'b0010111: v = int'(i & 32'hFFFFF000);
            7'b1101111: v = (i[31] ? -(1 << 20) : 0) + int'(i[19:12]) * 4096
                            + int'(i[20]) * 2048 + int'(i[30:21]) * 2;
            default: v = 0;
        endcase
        return 32'(v);
    endfunction

    function automatic logic [31:0] csr_model(input logic [11:0] a, input logic [63:0] cyc,
                                              input logic [63:0] inst);
        case (a)
            12'hC00, 12'hC01: return cyc[31:0];
            12'hC80, 12'hC81: return cyc[63:32];
            12'hC02:          return inst[31:0];
            12'hC82:          return inst[63:32];
            default:          return 32'h0;
        endcase
    endfunction

    // Expected outputs for one cycle, given the instruction and model state
    function automatic exp_t model(input bit rst, input logic [31:0] i, input bit s1,
                                   input logic [63:0] cyc, input logic [63:0] inst);
        exp_t e;
        int   f3, f7;
        bit   bad;
        // per-branch-funct3 ALU op and PC select (-1: reserved encoding)
        int   br_op [8];
        int   br_pc [8];
        br_op = '{0, 0, -1, -1, 2, 2, 3, 3};
        br_pc = '{3, 2, -1, -1, 2, 3, 2, 3};
        f3  = int'(i[14:12]);
        f7  = int'(i[31:25]);
        bad = 1'b0;
        e      = '0;
        e.ins  = i;
        e.kind = K_FULL;
        e.pc   = 3'd1;
        e.st0  = !s1;
        e.imm  = imm_model(i);
        e.csrd = csr_model(i[31:20], cyc, inst);
        if (rst) begin
            e.kind = K_RESET;
            return e;
        end
        case (i[6:0])
            7'b0110111: begin e.a0 = 1; e.aimm = 1; e.wen = 1; end
            7'b0010111: begin e.apc = 1; e.aimm = 1; e.wen = 1; end
            7'b1101111: begin e.apc = 1; e.b4 = 1; e.wen = 1; e.pc = 3'd4; end
            7'b1100111: if (f3 == 0) begin e.apc = 1; e.b4 = 1; e.wen = 1; e.pc = 3'd5; end
                        else bad = 1;
            7'b1100011: if (br_op[f3] < 0) bad = 1;
                        else begin
                            e.op  = 3'(br_op[f3]);
                            e.pc  = 3'(br_pc[f3]);
                            e.alt = (f3 < 2);
                        end
            7'b0000011: begin
                e.aimm = 1; e.dr = 1;
                if (s1) begin e.dreg = 1; e.wen = 1; end
                else e.pc = 3'd0;
            end
            7'b0100011: begin e.aimm = 1; e.dw = 1; end
            7'b0001111: ;
            7'b0010011: begin e.aimm = 1; e.op = 3'(f3); e.wen = 1; e.alt = (f3 == 5) && i[30]; end
            7'b0110011: begin
                if (f7 == 'h00 || f7 == 'h20) begin
                    e.op = 3'(f3); e.wen = 1;
                    e.alt = (f7 == 'h20) && (f3 == 0 || f3 == 5);
                end else if (f7 == 'h01 && MODEL_MUL) begin
                    e.op = 3'(f3); e.wen = 1; e.mul = 1;
                end else bad = 1;
            end
            7'b1110011: if (f3 != 0) begin e.csr = 1; e.wen = 1; end else bad = 1;
            default: bad = 1;
        endcase
        if (bad) begin
            e.kind = K_ILLEGAL;
            e.ill  = 1;
            e.wen  = 0;
            e.dr   = 0;
            e.dw   = 0;
            e.pc   = 3'd1;
        end
        return e;
    endfunction

    // Drive one cycle: apply stimulus after the edge, queue its expectation,
    // then advance the model past the next edge.
    task automatic step(input bit rst, input logic [31:0] i);
        bit is_load;
        @(posedge clk);
        #1;
        reset      = rst;
        dec_if.ins = i;
        sb.push_back(model(rst, i, m_s1, m_cyc, m_inst));
        is_load = (i[6:0] == 7'b0000011);
        if (rst) begin
            m_s1   = 0;
            m_cyc  = 0;
            m_inst = 0;
        end else begin
            m_cyc = m_cyc + 64'd1;
            if (!(is_load && !m_s1)) m_inst = m_inst + 64'd1;
            m_s1 = is_load && !m_s1;
        end
    endtask

    function automatic logic [31:0] rand_ins();
        logic [31:0] r;
        logic [11:0] csr_pick;
        int          k;
        r = $urandom();
        k = $urandom_range(0, 13);
        case (k)
            0:  r[6:0] = 7'b0110111;
            1:  r[6:0] = 7'b0010111;
            2:  r[6:0] = 7'b1101111;
            3:  r[6:0] = 7'b1100111;
            4:  r[6:0] = 7'b1100011;
            5:  r[6:0] = 7'b0000011;
            6:  r[6:0] = 7'b0100011;
            7:  r[6:0] = 7'b0001111;
            8:  r[6:0] = 7'b0010011;
            9:  r[6:0] = 7'b0110011;
            10: r[6:0] = 7'b1110011;
            11: return 32'hFFFFFFFF;
            default: ;
        endcase
        case ($urandom_range(0, 3))
            0: r[31:25] = 7'h00;
            1: r[31:25] = 7'h20;
            2: r[31:25] = 7'h01;
            default: ;
        endcase
        if (r[6:0] == 7'b1110011 && $urandom_range(0, 2) != 0) begin
            case ($urandom_range(0, 6))
                0: csr_pick = 12'hC00;
                1: csr_pick = 12'hC01;
                2: csr_pick = 12'hC80;
                3: csr_pick = 12'hC81;
                4: csr_pick = 12'hC02;
                5: csr_pick = 12'hC82;
                default: csr_pick = 12'(($urandom()));
            endcase
            r[31:20] = csr_pick;
        end
        return r;
    endfunction

    // Monitor: one queued expectation per cycle, sampled mid-cycle
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("op_illegal", e.ins, 32'(dec_if.op_illegal), 32'(e.ill));
                check("reg_wen",    e.ins, 32'(dec_if.reg_wen),    32'(e.wen));
                check("dmem_read",  e.ins, 32'(dec_if.dmem_read),  32'(e.dr));
                check("dmem_write", e.ins, 32'(dec_if.dmem_write), 32'(e.dw));
                check("pc_imm",     e.ins, 32'(dec_if.pc_imm),     32'(e.pc));
                check("stage0",     e.ins, 32'(dec_if.stage0),     32'(e.st0));
                if (e.kind == K_RESET) begin
                    check("rst_csr_reg", e.ins, 32'(dec_if.csr_reg), 32'(e.csr));
                end else begin
                    check("imm",       e.ins, dec_if.imm,       e.imm);
                    check("csr_rdata", e.ins, dec_if.csr_rdata, e.csrd);
                end
                if (e.kind == K_FULL) begin
                    check("alu_op",   e.ins, 32'(dec_if.alu_op),   32'(e.op));
                    check("alu_alt",  e.ins, 32'(dec_if.alu_alt),  32'(e.alt));
                    check("alu_imm",  e.ins, 32'(dec_if.alu_imm),  32'(e.aimm));
                    check("alu_a0",   e.ins, 32'(dec_if.alu_a0),   32'(e.a0));
                    check("alu_apc",  e.ins, 32'(dec_if.alu_apc),  32'(e.apc));
                    check("alu_b4",   e.ins, 32'(dec_if.alu_b4),   32'(e.b4));
                    check("alu_mul",  e.ins, 32'(dec_if.alu_mul),  32'(e.mul));
                    check("dmem_reg", e.ins, 32'(dec_if.dmem_reg), 32'(e.dreg));
                    check("csr_reg",  e.ins, 32'(dec_if.csr_reg),  32'(e.csr));
                end
            end
        end
    end

    // Driver
    initial begin : driver
        logic [31:0] cur;
        reset      = 1'b1;
        dec_if.ins = 32'h00000013;
        m_s1   = 0;
        m_cyc  = 0;
        m_inst = 0;
        @(posedge clk);

        // Reset with a load on the bus: controls must still read as a nop
        step(1, 32'h0040A103);
        // Ten nops, then read cycle and instret
        for (int n = 0; n < 10; n++) step(0, 32'h00000013);
        step(0, 32'hC00021F3);          // csrrs x3, cycle, x0
        step(0, 32'hC02021F3);          // csrrs x3, instret, x0
        step(0, 32'hC80021F3);          // cycleh
        step(0, 32'hFFF00093);          // addi x1, x0, -1
        step(0, 32'h0040A103);          // lw x2, 4(x1): address cycle
        step(0, 32'h0040A103);          //               write-back cycle
        step(0, 32'hFE20DCE3);          // bge x1, x2, -8
        step(0, 32'hFE209CE3);          // bne x1, x2, -8
        step(0, 32'h40000033);          // sub
        step(0, 32'h02000033);          // mul (legal only with MUL_EN)
        step(0, 32'hFFFFFFFF);          // illegal
        step(0, 32'h00000073);          // ecall: illegal
        step(0, 32'h0000A067);          // jalr with f3 != 0: illegal
        step(0, 32'h0000A063);          // branch f3 = 2: illegal
        // Reset arriving during the load write-back cycle
        step(0, 32'h0040A103);
        step(1, 32'h0040A103);
        step(0, 32'h0040A103);
        step(0, 32'h0040A103);
        step(0, 32'hC00021F3);

        // Randomised traffic; loads are normally held for their second cycle
        cur = rand_ins();
        for (int n = 0; n < 1500; n++) begin
            if (m_s1 && $urandom_range(0, 9) != 0) begin
                // keep cur: the held load word
            end else begin
                cur = rand_ins();
            end
            step(($urandom_range(0, 49) == 0), cur);
        end

        // Let the monitor drain; a leftover entry means a lost comparison
        repeat (3) @(posedge clk);
        tests_run++;
        if (sb.size() != 0) begin
            tests_failed++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
